// File: rtl/inst_fetch_bridge.sv
// rtl/inst_fetch_bridge.sv - instruction fetch responder between the PC and a req/ack memory bus
// One single-beat read per instruction; holds the word for IF/ID and stalls the PC until it is ready.
module inst_fetch_bridge #(
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        ce_i,
  input  logic [5:0]  stall,
  input  logic        flush_i,
  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        addr_err_o,
  output logic        stallreq_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] inst_q, inst_d;
  logic        err_q, err_d;
  logic        drop_q, drop_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= 32'h0;
      inst_q  <= NOP_INST;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
    err_d   = err_q;
    drop_d  = drop_q;
    unique case (state_q)
      S_IDLE: begin
        if (ce_i && !flush_i) begin
          addr_d = pc_i;
          if (pc_i[1:0] == 2'b00) begin
            state_d = S_BUSY;
          end else begin
            // misaligned: no bus cycle, hand back a NOP flagged as an error
            inst_d  = NOP_INST;
            err_d   = 1'b1;
            state_d = S_READY;
          end
        end
      end
      S_BUSY: begin
        if (bus_ack_i) begin
          if (drop_q || flush_i) begin
            drop_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            inst_d  = bus_rdata_i;
            err_d   = 1'b0;
            state_d = S_READY;
          end
        end else if (flush_i) begin
          // the request cannot be withdrawn, so remember to discard its data
          drop_d = 1'b1;
        end
      end
      S_READY: begin
        if (flush_i || !stall[1]) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are forced to their idle values while reset is asserted.
  always_comb begin
    bus_req_o    = 1'b0;
    bus_addr_o   = 32'h0;
    inst_o       = NOP_INST;
    inst_valid_o = 1'b0;
    addr_err_o   = 1'b0;
    stallreq_o   = 1'b0;
    if (!rst) begin
      bus_addr_o = addr_q;
      bus_req_o  = (state_q == S_BUSY);
      stallreq_o = ce_i && (state_q != S_READY);
      if (state_q == S_READY) begin
        inst_o       = inst_q;
        inst_valid_o = 1'b1;
        addr_err_o   = err_q;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// tb/tb_inst_fetch_bridge.sv - directed table-driven bench for inst_fetch_bridge
module tb_inst_fetch_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        ce_i;
  logic [5:0]  stall;
  logic        flush_i;
  logic        bus_req_o;
  logic [31:0] bus_addr_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        addr_err_o;
  logic        stallreq_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  inst_fetch_bridge #(.NOP_INST(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .ce_i(ce_i), .stall(stall), .flush_i(flush_i),
    .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o), .bus_ack_i(bus_ack_i),
    .bus_rdata_i(bus_rdata_i), .inst_o(inst_o), .inst_valid_o(inst_valid_o),
    .addr_err_o(addr_err_o), .stallreq_o(stallreq_o)
  );

  typedef struct {
    logic        rst, ce;
    logic [31:0] pc;
    logic        st1, fl, ack;
    logic [31:0] rd;
    logic        req;
    logic [31:0] addr, inst;
    logic        val, err, sreq;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h expected=%h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic ce, input logic [31:0] pc, input logic st1,
                     input logic fl, input logic ack, input logic [31:0] rd,
                     input logic req, input logic [31:0] addr, input logic [31:0] inst,
                     input logic val, input logic err, input logic sreq);
    vec_t v;
    v.rst = r; v.ce = ce; v.pc = pc; v.st1 = st1; v.fl = fl; v.ack = ack; v.rd = rd;
    v.req = req; v.addr = addr; v.inst = inst; v.val = val; v.err = err; v.sreq = sreq;
    vq.push_back(v);
  endtask

  task automatic drive(input logic r, input logic ce, input logic [31:0] pc, input logic st1,
                       input logic fl, input logic ack, input logic [31:0] rd);
    rst = r; ce_i = ce; pc_i = pc; stall = {4'b0, st1, 1'b0};
    flush_i = fl; bus_ack_i = ack; bus_rdata_i = rd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nw;
    bit seen;
    drive(1, 1, 32'h4, 0, 1, 1, 32'h0);

    //   rst ce pc        st fl ack rdata          req addr      inst          val err sreq
    add(1, 1, 32'h4,  0, 1, 1, 32'h0,          0, 32'h0,  32'h0,        0, 0, 0); // reset
    add(1, 1, 32'h4,  0, 1, 1, 32'h0,          0, 32'h0,  32'h0,        0, 0, 0);
    add(0, 1, 32'h4,  0, 0, 0, 32'h0,          0, 32'h0,  32'h0,        0, 0, 1); // idle after release
    add(0, 1, 32'h4,  0, 0, 1, 32'h2401_0005,  1, 32'h4,  32'h0,        0, 0, 1); // zero-wait
    add(0, 1, 32'h4,  0, 0, 0, 32'h0,          0, 32'h4,  32'h2401_0005,1, 0, 0);
    add(0, 0, 32'h4,  0, 0, 0, 32'h0,          0, 32'h4,  32'h0,        0, 0, 0);
    add(0, 1, 32'h10, 0, 0, 0, 32'h0,          0, 32'h4,  32'h0,        0, 0, 1); // 3 wait states
    add(0, 1, 32'h10, 0, 0, 0, 32'h0,          1, 32'h10, 32'h0,        0, 0, 1);
    add(0, 1, 32'h10, 0, 0, 0, 32'h0,          1, 32'h10, 32'h0,        0, 0, 1);
    add(0, 1, 32'h10, 0, 0, 0, 32'h0,          1, 32'h10, 32'h0,        0, 0, 1);
    add(0, 1, 32'h10, 0, 0, 1, 32'h1111_1111,  1, 32'h10, 32'h0,        0, 0, 1);
    add(0, 1, 32'h10, 1, 0, 0, 32'h0,          0, 32'h10, 32'h1111_1111,1, 0, 0); // downstream hold
    add(0, 1, 32'h10, 1, 0, 1, 32'hFFFF_FFFF,  0, 32'h10, 32'h1111_1111,1, 0, 0);
    add(0, 1, 32'h10, 0, 0, 0, 32'h0,          0, 32'h10, 32'h1111_1111,1, 0, 0);
    add(0, 1, 32'h20, 0, 0, 0, 32'h0,          0, 32'h10, 32'h0,        0, 0, 1); // flush in BUSY
    add(0, 1, 32'h20, 0, 0, 0, 32'h0,          1, 32'h20, 32'h0,        0, 0, 1);
    add(0, 1, 32'h20, 0, 1, 0, 32'h0,          1, 32'h20, 32'h0,        0, 0, 1);
    add(0, 1, 32'h20, 0, 0, 0, 32'h0,          1, 32'h20, 32'h0,        0, 0, 1);
    add(0, 1, 32'h20, 0, 0, 1, 32'hDEAD_BEEF,  1, 32'h20, 32'h0,        0, 0, 1);
    add(0, 1, 32'h8,  0, 0, 0, 32'h0,          0, 32'h20, 32'h0,        0, 0, 1); // refetch
    add(0, 1, 32'h8,  0, 0, 1, 32'h8C22_0000,  1, 32'h8,  32'h0,        0, 0, 1);
    add(0, 1, 32'h8,  0, 0, 0, 32'h0,          0, 32'h8,  32'h8C22_0000,1, 0, 0);
    add(0, 1, 32'h6,  0, 0, 0, 32'h0,          0, 32'h8,  32'h0,        0, 0, 1); // misaligned
    add(0, 1, 32'h6,  0, 0, 0, 32'h0,          0, 32'h6,  32'h0,        1, 1, 0);
    add(0, 0, 32'h6,  0, 0, 0, 32'h0,          0, 32'h6,  32'h0,        0, 0, 0);
    add(0, 1, 32'hC,  0, 0, 0, 32'h0,          0, 32'h6,  32'h0,        0, 0, 1); // ack+flush together
    add(0, 1, 32'hC,  0, 1, 1, 32'hAAAA_5555,  1, 32'hC,  32'h0,        0, 0, 1);
    add(0, 1, 32'hC,  0, 1, 0, 32'h0,          0, 32'hC,  32'h0,        0, 0, 1); // flush blocks start
    add(0, 1, 32'hC,  0, 0, 0, 32'h0,          0, 32'hC,  32'h0,        0, 0, 1);
    add(0, 1, 32'hC,  0, 0, 1, 32'h1234_5678,  1, 32'hC,  32'h0,        0, 0, 1);
    add(0, 1, 32'hC,  1, 1, 0, 32'h0,          0, 32'hC,  32'h1234_5678,1, 0, 0); // flush beats stall
    add(0, 0, 32'hC,  1, 0, 0, 32'h0,          0, 32'hC,  32'h0,        0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].ce, vq[i].pc, vq[i].st1, vq[i].fl, vq[i].ack, vq[i].rd);
      @(negedge clk);
      chk("bus_req",    i, {31'b0, bus_req_o},    {31'b0, vq[i].req});
      chk("bus_addr",   i, bus_addr_o,            vq[i].addr);
      chk("inst",       i, inst_o,                vq[i].inst);
      chk("inst_valid", i, {31'b0, inst_valid_o}, {31'b0, vq[i].val});
      chk("addr_err",   i, {31'b0, addr_err_o},   {31'b0, vq[i].err});
      chk("stallreq",   i, {31'b0, stallreq_o},   {31'b0, vq[i].sreq});
      next_cycle();
    end

    // reset while a bus cycle is outstanding
    drive(0, 1, 32'h40, 0, 0, 0, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("rstbusy_req", 100, {31'b0, bus_req_o}, 32'h1);
    chk("rstbusy_addr", 100, bus_addr_o, 32'h40);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("rstbusy_req_in_rst", 101, {31'b0, bus_req_o}, 32'h0);
    chk("rstbusy_addr_in_rst", 101, bus_addr_o, 32'h0);
    chk("rstbusy_sreq_in_rst", 101, {31'b0, stallreq_o}, 32'h0);
    next_cycle();
    drive(0, 0, 32'h40, 0, 0, 0, 32'h0);
    @(negedge clk);
    chk("rstbusy_req_after", 102, {31'b0, bus_req_o}, 32'h0);
    chk("rstbusy_addr_after", 102, bus_addr_o, 32'h0);
    next_cycle();

    // random wait-state count, bounded wait for the instruction
    nw = $urandom_range(0, 5);
    drive(0, 1, 32'h44, 0, 0, 0, 32'h0);
    next_cycle();
    for (int k = 0; k <= nw; k++) begin
      bus_ack_i = (k == nw);
      bus_rdata_i = 32'hCAFE_F00D;
      @(negedge clk);
      chk("rw_req", 200 + k, {31'b0, bus_req_o}, 32'h1);
      chk("rw_addr", 200 + k, bus_addr_o, 32'h44);
      next_cycle();
    end
    bus_ack_i = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (inst_valid_o) seen = 1'b1;
      else next_cycle();
    end
    chk("rw_valid_seen", 300, {31'b0, seen}, 32'h1);
    chk("rw_inst", 300, inst_o, 32'hCAFE_F00D);
    next_cycle();
    ce_i = 1'b0;
    @(negedge clk);
    chk("rw_consumed", 301, {31'b0, inst_valid_o}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
